// File: rtl/mix_columns_seq.sv
// -----------------------------------------------------------------------------
// mix_columns_seq
//   Sequential AES MixColumns / InvMixColumns engine for the iterative round
//   datapath (between (Inv)ShiftRows and AddRoundKey). A 128-bit state is
//   accepted under a valid/ready handshake together with a mode bit, then
//   COLS_PER_CYC columns are transformed per cycle. The finished state is
//   registered onto data_out one cycle after the last compute cycle and held
//   until the consumer takes it.
//
//   State byte layout: data_*[0:127], bit 0 is the MSB, byte(row r, col c)
//   lives at [32*r + 8*c +: 8].
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   data_in / inv_in valid
//   in_ready   out  engine can accept a block (combinational)
//   data_in    in   128-bit input state
//   inv_in     in   0 = MixColumns, 1 = InvMixColumns (latched per block)
//   out_valid  out  data_out valid
//   out_ready  in   consumer accepts data_out
//   data_out   out  128-bit result state
//   busy       out  high while columns are being computed
// -----------------------------------------------------------------------------
module mix_columns_seq #(
  parameter int COLS_PER_CYC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] data_in,
  input  logic         inv_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] data_out,
  output logic         busy
);

  localparam int NCYC = 4 / COLS_PER_CYC;
  // col_cnt value seen during the final compute cycle of a block.
  localparam logic [2:0] LAST_COL = 3'((NCYC - 1) * COLS_PER_CYC);
  localparam logic [2:0] STEP     = 3'(COLS_PER_CYC);

  generate
    if (!(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4)) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYC must be 1, 2 or 4");
    end
  endgenerate

  // WB is the cycle that copies the finished work register onto data_out.
  typedef enum logic [1:0] {IDLE, BUSY, WB, DONE} state_e;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, polynomial x^8+x^4+x^3+x+1
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      4'h1:    return b;
      4'h2:    return x2;
      4'h3:    return x2 ^ b;
      4'h9:    return x8 ^ b;
      4'hb:    return x8 ^ x2 ^ b;
      4'hd:    return x8 ^ x4 ^ b;
      4'he:    return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

  // Replace column c of state s with its (Inv)MixColumns transform.
  // Row i uses the coefficient row rotated right by i.
  function automatic logic [0:127] mix_at(input logic [0:127] s, input int c, input logic inv);
    logic [0:127] res;
    logic [7:0]   a [4];
    logic [3:0]   coef [4];
    logic [7:0]   acc;
    res = s;
    if (inv) begin
      coef[0] = 4'he; coef[1] = 4'hb; coef[2] = 4'hd; coef[3] = 4'h9;
    end else begin
      coef[0] = 4'h2; coef[1] = 4'h3; coef[2] = 4'h1; coef[3] = 4'h1;
    end
    for (int r = 0; r < 4; r++) a[r] = s[32*r + 8*c +: 8];
    for (int i = 0; i < 4; i++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], coef[(j - i + 4) % 4]);
      res[32*i + 8*c +: 8] = acc;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e       state_q, state_d;
  logic [2:0]   col_cnt_q, col_cnt_d;
  logic [0:127] work_q, work_d;
  logic         inv_q, inv_d;
  logic         out_valid_q, out_valid_d;
  logic [0:127] data_out_q, data_out_d;
  logic [0:127] mixed;

  // Work register with this cycle's columns replaced.
  always_comb begin
    mixed = work_q;
    for (int k = 0; k < COLS_PER_CYC; k++) begin
      mixed = mix_at(mixed, (int'(col_cnt_q) + k) % 4, inv_q);
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    work_d      = work_q;
    inv_d       = inv_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    in_ready    = 1'b0;
    busy        = 1'b0;

    case (state_q)
      IDLE: in_ready = 1'b1;
      BUSY: begin
        busy      = 1'b1;
        work_d    = mixed;
        col_cnt_d = col_cnt_q + STEP;
        if (col_cnt_q == LAST_COL) state_d = WB;
      end
      WB: begin
        out_valid_d = 1'b1;
        data_out_d  = work_q;
        state_d     = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept overrides the per-state next state (covers DONE back-to-back).
    if (in_valid && in_ready) begin
      state_d   = BUSY;
      work_d    = data_in;
      inv_d     = inv_in;
      col_cnt_d = 3'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_cnt_q   <= 3'd0;
      work_q      <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      work_q      <= work_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule
